// File: rtl/weighted_sum_stream.sv
// Pipelined N-input dot product plus bias, with optional ReLU and saturation to OUT_WIDTH.
// Latency: 2+ceil(log2(NUM_INPUTS)) cycles from input transfer to out_valid; one vector per cycle.
// Backpressure: global stall; every stage freezes while out_valid && !out_ready, in_ready = !out_valid || out_ready.
module weighted_sum_stream #(
    parameter int NUM_INPUTS = 4,
    parameter int BIT_LENGTH = 8,
    parameter int SIGNED     = 1,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_INPUTS-1:0][BIT_LENGTH-1:0] weights,
    input  logic [NUM_INPUTS-1:0][BIT_LENGTH-1:0] inputs,
    input  logic [2*BIT_LENGTH-1:0]               bias,
    input  logic                                  relu_en,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [OUT_WIDTH-1:0]                  out_sum,
    output logic                                  overflow
);

    localparam int T     = $clog2(NUM_INPUTS);
    localparam int PW    = 2 * BIT_LENGTH;
    localparam int ACC_W = PW + T;
    localparam int SW    = ACC_W + 1;
    localparam int CW    = (ACC_W + 2 > OUT_WIDTH + 1) ? ACC_W + 2 : OUT_WIDTH + 1;

    localparam logic signed [CW-1:0] ONE   = CW'(1);
    localparam logic signed [CW-1:0] MAX_V = (SIGNED != 0) ? (ONE <<< (OUT_WIDTH - 1)) - ONE
                                                           : (ONE <<< OUT_WIDTH) - ONE;
    localparam logic signed [CW-1:0] MIN_V = (SIGNED != 0) ? -(ONE <<< (OUT_WIDTH - 1)) : '0;

    // Number of live operands at a given tree level.
    function automatic int lvl_cnt(input int l);
        int c;
        c = NUM_INPUTS;
        for (int i = 0; i < l; i++) c = (c + 1) / 2;
        return c;
    endfunction

    function automatic int clip(input int i);
        return (i < NUM_INPUTS) ? i : 0;
    endfunction

    logic                 advance;
    logic [T:0]           vld_q;
    logic [T:0]           relu_q;
    logic [PW-1:0]        bias_q [0:T];
    // Every level is held at the final width, extended per SIGNED, so partial sums never wrap.
    logic [ACC_W-1:0]     lvl_q  [0:T][0:NUM_INPUTS-1];
    logic [ACC_W-1:0]     prod   [0:NUM_INPUTS-1];

    logic [SW-1:0]        fin_sum;
    logic signed [CW-1:0] fin_val;
    logic [OUT_WIDTH-1:0] sat_sum;
    logic                 sat_ovf;

    assign in_ready = !out_valid || out_ready;
    assign advance  = in_ready;

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (SIGNED != 0)
                prod[i] = ACC_W'($signed(weights[i])) * ACC_W'($signed(inputs[i]));
            else
                prod[i] = ACC_W'(weights[i]) * ACC_W'(inputs[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            for (int i = 0; i < NUM_INPUTS; i++) lvl_q[0][i] <= prod[i];
            bias_q[0] <= bias;
            relu_q[0] <= relu_en;
            for (int l = 1; l <= T; l++) begin
                bias_q[l] <= bias_q[l-1];
                relu_q[l] <= relu_q[l-1];
                for (int j = 0; j < NUM_INPUTS; j++) begin
                    if (2 * j + 1 < lvl_cnt(l - 1))
                        lvl_q[l][j] <= lvl_q[l-1][clip(2 * j)] + lvl_q[l-1][clip(2 * j + 1)];
                    else if (2 * j < lvl_cnt(l - 1))
                        lvl_q[l][j] <= lvl_q[l-1][clip(2 * j)];
                    else
                        lvl_q[l][j] <= '0;
                end
            end
        end
    end

    always_comb begin
        if (SIGNED != 0) begin
            fin_sum = SW'($signed(lvl_q[T][0])) + SW'($signed(bias_q[T]));
            fin_val = CW'($signed(fin_sum));
        end else begin
            fin_sum = SW'(lvl_q[T][0]) + SW'(bias_q[T]);
            fin_val = CW'(fin_sum);
        end
        if ((SIGNED != 0) && relu_q[T] && (fin_val < 0))
            fin_val = '0;
        sat_sum = fin_val[OUT_WIDTH-1:0];
        sat_ovf = 1'b0;
        if (fin_val > MAX_V) begin
            sat_sum = MAX_V[OUT_WIDTH-1:0];
            sat_ovf = 1'b1;
        end else if (fin_val < MIN_V) begin
            sat_sum = MIN_V[OUT_WIDTH-1:0];
            sat_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            overflow  <= 1'b0;
        end else if (advance) begin
            vld_q[0] <= in_valid;
            for (int l = 1; l <= T; l++) vld_q[l] <= vld_q[l-1];
            out_valid <= vld_q[T];
            out_sum   <= sat_sum;
            overflow  <= sat_ovf;
        end
    end

endmodule

// File: tb/tb_weighted_sum_stream.sv
// Bench for weighted_sum_stream: a signed 4-input instance and an unsigned 5-input instance,
// checked with constant vector tables, hand sequences and a queue-based reference model.
module tb_weighted_sum_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic            a_in_valid, a_in_ready, a_relu, a_out_valid, a_out_ready, a_ovf;
    logic [3:0][7:0] a_w, a_x;
    logic [15:0]     a_bias, a_out_sum;

    logic            b_in_valid, b_in_ready, b_relu, b_out_valid, b_out_ready, b_ovf;
    logic [4:0][7:0] b_w, b_x;
    logic [15:0]     b_bias, b_out_sum;

    int total = 0;
    int bad   = 0;
    logic [16:0] qa[$];
    logic [16:0] qb[$];

    weighted_sum_stream #(.NUM_INPUTS(4), .BIT_LENGTH(8), .SIGNED(1), .OUT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .weights(a_w), .inputs(a_x), .bias(a_bias), .relu_en(a_relu),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum), .overflow(a_ovf)
    );

    weighted_sum_stream #(.NUM_INPUTS(5), .BIT_LENGTH(8), .SIGNED(0), .OUT_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .weights(b_w), .inputs(b_x), .bias(b_bias), .relu_en(b_relu),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum), .overflow(b_ovf)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Exact dot product in 64-bit arithmetic, then ReLU and clamp; returns {overflow, out_sum}.
    function automatic logic [16:0] model(input int n, input bit sgn,
                                          input logic [4:0][7:0] w, input logic [4:0][7:0] x,
                                          input logic [15:0] bias, input logic relu);
        longint acc, hi, lo;
        logic ovf;
        acc = sgn ? longint'($signed(bias)) : longint'(bias);
        for (int i = 0; i < n; i++)
            acc += sgn ? longint'($signed(w[i])) * longint'($signed(x[i]))
                       : longint'(w[i]) * longint'(x[i]);
        if (sgn && relu && acc < 0) acc = 0;
        hi  = sgn ? 32767 : 65535;
        lo  = sgn ? -32768 : 0;
        ovf = 1'b0;
        if (acc > hi) begin acc = hi; ovf = 1'b1; end
        else if (acc < lo) begin acc = lo; ovf = 1'b1; end
        return {ovf, 16'(acc)};
    endfunction

    function automatic logic [3:0][7:0] v4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [4:0][7:0] v5(input int a, input int b, input int c, input int d, input int e);
        return {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    always @(negedge clk) begin
        logic [16:0] e;
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) chk("a_sb_extra", 1, 0);
                else begin
                    e = qa.pop_front();
                    chk("a_sb_sum", int'($signed(a_out_sum)), int'($signed(e[15:0])));
                    chk("a_sb_ovf", int'(a_ovf), int'(e[16]));
                end
            end
            if (a_in_valid && a_in_ready)
                qa.push_back(model(4, 1'b1, {8'd0, a_w}, {8'd0, a_x}, a_bias, a_relu));
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) chk("b_sb_extra", 1, 0);
                else begin
                    e = qb.pop_front();
                    chk("b_sb_sum", int'(b_out_sum), int'(e[15:0]));
                    chk("b_sb_ovf", int'(b_ovf), int'(e[16]));
                end
            end
            if (b_in_valid && b_in_ready)
                qb.push_back(model(5, 1'b0, b_w, b_x, b_bias, b_relu));
        end
    end

    task automatic run_a(input string nm, input logic [3:0][7:0] w, input logic [3:0][7:0] x,
                         input logic [15:0] bias, input logic relu, input int exp_sum, input int exp_ovf);
        int lat = 0;
        int s = 0;
        int o = 0;
        a_w = w; a_x = x; a_bias = bias; a_relu = relu; a_out_ready = 1'b1; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            @(negedge clk);
            if (a_out_valid) begin lat = c; s = int'($signed(a_out_sum)); o = int'(a_ovf); end
        end
        chk({nm, "_latency"}, lat, 4);
        if (lat != 0) begin
            chk({nm, "_sum"}, s, exp_sum);
            chk({nm, "_ovf"}, o, exp_ovf);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_b(input string nm, input logic [4:0][7:0] w, input logic [4:0][7:0] x,
                         input logic [15:0] bias, input logic relu, input int exp_sum, input int exp_ovf);
        int lat = 0;
        int s = 0;
        int o = 0;
        b_w = w; b_x = x; b_bias = bias; b_relu = relu; b_out_ready = 1'b1; b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            @(negedge clk);
            if (b_out_valid) begin lat = c; s = int'(b_out_sum); o = int'(b_ovf); end
        end
        chk({nm, "_latency"}, lat, 5);
        if (lat != 0) begin
            chk({nm, "_sum"}, s, exp_sum);
            chk({nm, "_ovf"}, o, exp_ovf);
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [3:0][7:0] w;
        logic [3:0][7:0] x;
        logic [15:0]     bias;
        logic            relu;
        int              sum;
        int              ovf;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        logic acc = 1'b0;
        logic prev_hold, saw_low, seen;
        logic [15:0] prev_sum;
        int k, n_got;

        tbl[0]  = '{v4(1, 2, 3, 4), v4(10, 20, 30, 40), 16'd0, 1'b0, 300, 0};
        tbl[1]  = '{v4(-128, -128, -128, -128), v4(-128, -128, -128, -128), 16'd0, 1'b0, 32767, 1};
        tbl[2]  = '{v4(-1, -1, -1, -1), v4(5, 5, 5, 5), 16'd3, 1'b0, -17, 0};
        tbl[3]  = '{v4(-1, -1, -1, -1), v4(5, 5, 5, 5), 16'd3, 1'b1, 0, 0};
        tbl[4]  = '{v4(1, 2, 3, 4), v4(10, 20, 30, 40), 16'd0, 1'b1, 300, 0};
        tbl[5]  = '{v4(127, 127, 0, 0), v4(127, 127, 0, 0), 16'd509, 1'b0, 32767, 0};
        tbl[6]  = '{v4(127, 127, 0, 0), v4(127, 127, 0, 0), 16'd510, 1'b0, 32767, 1};
        tbl[7]  = '{v4(-128, 0, 0, 0), v4(127, 0, 0, 0), 16'(-16512), 1'b0, -32768, 0};
        tbl[8]  = '{v4(-128, 0, 0, 0), v4(127, 0, 0, 0), 16'(-16513), 1'b0, -32768, 1};
        tbl[9]  = '{v4(-128, 0, 0, 0), v4(127, 0, 0, 0), 16'(-16513), 1'b1, 0, 0};
        tbl[10] = '{v4(-128, -128, -128, -128), v4(127, 127, 127, 127), 16'(-32768), 1'b0, -32768, 1};
        tbl[11] = '{v4(127, 127, 127, 127), v4(-128, -128, -128, -128), 16'd32767, 1'b0, -32257, 0};

        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_w = '0; a_x = '0; a_bias = '0; a_relu = 1'b0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_w = '0; b_x = '0; b_bias = '0; b_relu = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("a_rst_out_valid", int'(a_out_valid), 0);
        chk("a_rst_out_sum", int'(a_out_sum), 0);
        chk("a_rst_overflow", int'(a_ovf), 0);
        chk("a_rst_in_ready", int'(a_in_ready), 1);
        chk("b_rst_out_valid", int'(b_out_valid), 0);
        chk("b_rst_out_sum", int'(b_out_sum), 0);
        chk("b_rst_overflow", int'(b_ovf), 0);
        chk("b_rst_in_ready", int'(b_in_ready), 1);
        @(posedge clk); #1;
        b_out_ready = 1'b1;

        for (int i = 0; i < 12; i++)
            run_a($sformatf("tbl%0d", i), tbl[i].w, tbl[i].x, tbl[i].bias, tbl[i].relu, tbl[i].sum, tbl[i].ovf);

        // Back-to-back stream with a 5-cycle output stall in the middle.
        k = 1; n_got = 0; prev_hold = 1'b0; prev_sum = '0; saw_low = 1'b0;
        a_out_ready = 1'b1; a_bias = '0; a_relu = 1'b0; a_w = v4(1, 1, 1, 1); a_x = v4(k, k, k, k);
        a_in_valid = 1'b1;
        for (int c = 0; c < 60 && n_got < 8; c++) begin
            @(negedge clk);
            if (prev_hold) begin
                chk("s5_hold_valid", int'(a_out_valid), 1);
                chk("s5_hold_sum", int'(a_out_sum), int'(prev_sum));
            end
            if (!a_in_ready) saw_low = 1'b1;
            if (a_out_valid && a_out_ready) begin
                chk("s5_order", int'($signed(a_out_sum)), 4 * (n_got + 1));
                n_got++;
            end
            prev_hold = a_out_valid && !a_out_ready;
            prev_sum  = a_out_sum;
            acc = a_in_valid && a_in_ready;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k > 8) a_in_valid = 1'b0;
                else a_x = v4(k, k, k, k);
            end
            a_out_ready = !(c >= 5 && c < 10);
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        chk("s5_count", n_got, 8);
        chk("s5_in_ready_dropped", int'(saw_low), 1);

        // Reset with three vectors in flight.
        for (int v = 1; v <= 3; v++) begin
            a_w = v4(1, 1, 1, 1); a_x = v4(v, v, v, v); a_in_valid = 1'b1;
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        chk("s6_in_ready", int'(a_in_ready), 1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (a_out_valid) seen = 1'b1;
        end
        chk("s6_no_out_valid", int'(seen), 0);
        @(posedge clk); #1;
        b_out_ready = 1'b1;
        run_a("s6_next", v4(1, 2, 3, 4), v4(10, 20, 30, 40), 16'd0, 1'b0, 300, 0);

        // Random traffic on the signed instance, scored by the reference model.
        acc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!a_in_valid || acc) begin
                a_w = $urandom;
                a_x = ($urandom % 4 == 0) ? ($urandom_range(0, 1) ? 32'h80808080 : 32'h7f7f7f7f) : $urandom;
                a_bias = 16'($urandom);
                a_relu = 1'($urandom);
                a_in_valid = ($urandom % 4) != 0;
            end
            a_out_ready = ($urandom % 4) != 0;
            @(negedge clk);
            acc = a_in_valid && a_in_ready;
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        for (int c = 0; c < 30 && qa.size() != 0; c++) @(posedge clk);
        @(negedge clk);
        chk("a_drain", qa.size(), 0);
        @(posedge clk); #1;

        // Unsigned 5-input instance.
        run_b("b_basic", v5(1, 2, 3, 4, 5), v5(10, 20, 30, 40, 50), 16'd0, 1'b0, 550, 0);
        run_b("b_relu_noeffect", v5(1, 2, 3, 4, 5), v5(10, 20, 30, 40, 50), 16'd0, 1'b1, 550, 0);
        run_b("b_max", v5(255, 255, 255, 255, 255), v5(255, 255, 255, 255, 255), 16'd0, 1'b0, 65535, 1);
        run_b("b_edge", v5(255, 255, 0, 0, 0), v5(255, 1, 0, 0, 0), 16'd255, 1'b0, 65535, 0);
        run_b("b_edge_over", v5(255, 255, 0, 0, 0), v5(255, 1, 0, 0, 0), 16'd256, 1'b0, 65535, 1);

        acc = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!b_in_valid || acc) begin
                b_w = 40'({$urandom, $urandom});
                b_x = 40'({$urandom, $urandom});
                b_bias = 16'($urandom);
                b_relu = 1'($urandom);
                b_in_valid = ($urandom % 4) != 0;
            end
            b_out_ready = ($urandom % 4) != 0;
            @(negedge clk);
            acc = b_in_valid && b_in_ready;
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        for (int c = 0; c < 30 && qb.size() != 0; c++) @(posedge clk);
        @(negedge clk);
        chk("b_drain", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
